// File: rtl/muldiv_issue.sv
// muldiv_issue
//   Issue/retire controller between the RV32M decode in execute and the
//   multi-cycle mul_div unit. One M-op is in flight at a time. Divide-by-zero
//   and signed-overflow divides are answered locally without launching the
//   unit. The result is held for writeback under a valid/ready handshake.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   in_valid_i / in_ready_o       execute-stage request / stall (ready = IDLE)
//   in_funct3_i, in_rd_i          RV32M funct3 and destination register
//   in_rs1_val_i, in_rs2_val_i    operand values
//   flush_i                       kill the current operation
//   md_start_o                    one-cycle launch pulse to mul_div
//   md_opcode_o, md_rs1_o/rs2_o   registered funct3 and operands for mul_div
//   md_busy_i, md_ready_i         mul_div busy / result-valid pulse
//   md_result_i                   mul_div result
//   wb_valid_o / wb_ready_i       writeback handshake
//   wb_rd_o, wb_data_o            held destination and result
module muldiv_issue #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      in_funct3_i,
    input  logic [RA_W-1:0] in_rd_i,
    input  logic [XLEN-1:0] in_rs1_val_i,
    input  logic [XLEN-1:0] in_rs2_val_i,
    input  logic            flush_i,
    output logic            md_start_o,
    output logic [2:0]      md_opcode_o,
    output logic [XLEN-1:0] md_rs1_o,
    output logic [XLEN-1:0] md_rs2_o,
    input  logic            md_busy_i,
    input  logic            md_ready_i,
    input  logic [XLEN-1:0] md_result_i,
    output logic            wb_valid_o,
    input  logic            wb_ready_i,
    output logic [RA_W-1:0] wb_rd_o,
    output logic [XLEN-1:0] wb_data_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_e;

    localparam logic [2:0]      F_DIV   = 3'b100;
    localparam logic [2:0]      F_REM   = 3'b110;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q;
    logic [2:0]      opcode_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic            wb_valid_q;
    logic [RA_W-1:0] wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    logic            accept;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_data;

    // Accepting an op with rd == 0 consumes it without any further effect.
    assign accept = (state_q == S_IDLE) && in_valid_i && !flush_i;

    // funct3[2] selects the divide group, funct3[1] picks REM over DIV.
    always_comb begin
        div_zero     = in_funct3_i[2] && (in_rs2_val_i == '0);
        div_ovf      = ((in_funct3_i == F_DIV) || (in_funct3_i == F_REM)) &&
                       (in_rs1_val_i == INT_MIN) && (in_rs2_val_i == '1);
        special      = div_zero || div_ovf;
        special_data = '0;
        if (div_zero) begin
            special_data = in_funct3_i[1] ? in_rs1_val_i : '1;
        end else if (div_ovf) begin
            special_data = in_funct3_i[1] ? '0 : INT_MIN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            opcode_q   <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && (in_rd_i != '0)) begin
                        wb_rd_q <= in_rd_i;
                        if (special) begin
                            wb_data_q  <= special_data;
                            wb_valid_q <= 1'b1;
                            state_q    <= S_HOLD;
                        end else begin
                            opcode_q <= in_funct3_i;
                            rs1_q    <= in_rs1_val_i;
                            rs2_q    <= in_rs2_val_i;
                            state_q  <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    // Leaving LAUNCH without flush means md_start fired this cycle.
                    if (flush_i) begin
                        state_q <= S_IDLE;
                    end else if (!md_busy_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The unit cannot be aborted: a flush waits out its result
                    // in DRAIN unless that result is arriving right now.
                    if (flush_i) begin
                        state_q <= md_ready_i ? S_IDLE : S_DRAIN;
                    end else if (md_ready_i) begin
                        wb_data_q  <= md_result_i;
                        wb_valid_q <= 1'b1;
                        state_q    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (flush_i || wb_ready_i) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (md_ready_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // md_start must never coincide with md_busy, so it is gated by the live
    // busy input rather than registered; it is also suppressed by a flush
    // arriving in the launch cycle.
    assign md_start_o  = (state_q == S_LAUNCH) && !md_busy_i && !flush_i;
    assign in_ready_o  = (state_q == S_IDLE);
    assign md_opcode_o = opcode_q;
    assign md_rs1_o    = rs1_q;
    assign md_rs2_o    = rs2_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_data_o   = wb_data_q;

endmodule

// File: tb/tb_muldiv_issue.sv
module tb_muldiv_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic        flush = 1'b0;
    logic        md_start;
    logic [2:0]  md_opcode;
    logic [31:0] md_rs1;
    logic [31:0] md_rs2;
    logic        md_busy;
    logic        md_ready = 1'b0;
    logic [31:0] md_result = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    muldiv_issue #(.XLEN(32), .RA_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_funct3_i(in_funct3),
        .in_rd_i(in_rd), .in_rs1_val_i(in_rs1), .in_rs2_val_i(in_rs2),
        .flush_i(flush),
        .md_start_o(md_start), .md_opcode_o(md_opcode), .md_rs1_o(md_rs1),
        .md_rs2_o(md_rs2), .md_busy_i(md_busy), .md_ready_i(md_ready),
        .md_result_i(md_result),
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_rd_o(wb_rd),
        .wb_data_o(wb_data)
    );

    typedef struct {logic [4:0] rd; logic [31:0] data;} wb_t;
    typedef struct {logic [2:0] f3; logic [31:0] a; logic [31:0] b;} ln_t;

    wb_t  exp_q[$];
    ln_t  ln_q[$];
    int   ncmp = 0;
    int   nfail = 0;
    int   start_cnt = 0;
    int   kfix = 3;
    bit   stab_en = 1'b1;
    int   rdy_mode = 0;      // 0: always ready, 1: random, 2: held low
    bit   busy_rand = 1'b0;
    logic ext_busy = 1'b0;
    logic mdl_busy = 1'b0;

    assign md_busy = mdl_busy | ext_busy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        ncmp++;
        nfail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // RV32M architectural result, straight from the ISA rules.
    function automatic logic [31:0] golden(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        p  = '0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return (f3 >= 3'd4 && b == 0) ||
               ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Scoreboard monitor: pops one expectation per writeback handshake.
    initial begin : monitor
        wb_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    flag("wb_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, e.data);
                end
            end
        end
    end

    // mul_div stand-in: latency kfix (or random 1..8). It returns a poison
    // value for cases the controller must never launch.
    initial begin : mdl
        logic        st;
        logic        prev;
        ln_t         cap;
        ln_t         e;
        logic [31:0] res;
        int          cnt;
        prev = 1'b0; cnt = 0; res = '0;
        cap = '{3'd0, 32'd0, 32'd0};
        forever begin
            @(negedge clk);
            st = md_start;
            if (st) begin
                start_cnt++;
                chk("start_while_busy", md_busy, 0);
                chk("start_back_to_back", prev, 0);
                cap = '{md_opcode, md_rs1, md_rs2};
                if (ln_q.size() == 0) begin
                    flag("start_unexpected");
                end else begin
                    e = ln_q.pop_front();
                    chk("md_opcode", cap.f3, e.f3);
                    chk("md_rs1", cap.a, e.a);
                    chk("md_rs2", cap.b, e.b);
                end
                res = is_special(cap.f3, cap.a, cap.b) ? 32'hDEAD_BEEF
                                                       : golden(cap.f3, cap.a, cap.b);
            end else if (cnt > 0 && stab_en && rst_n) begin
                chk("md_opcode_stable", md_opcode, cap.f3);
                chk("md_rs1_stable", md_rs1, cap.a);
                chk("md_rs2_stable", md_rs2, cap.b);
            end
            prev = st;
            @(posedge clk); #1;
            md_ready = 1'b0;
            if (st) cnt = (kfix > 0) ? kfix : int'($urandom_range(1, 8));
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    md_ready  = 1'b1;
                    md_result = res;
                    mdl_busy  = 1'b0;
                end else begin
                    mdl_busy = 1'b1;
                end
            end
        end
    end

    initial begin : env_drv
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       wb_ready = 1'b1;
                1:       wb_ready = 1'($urandom_range(0, 1));
                default: wb_ready = 1'b0;
            endcase
            if (busy_rand) ext_busy = ($urandom_range(0, 3) == 0);
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // kind 0: normal, 1: flush with in_valid, 2: launched then killed,
    // 3: killed before launch. Returns at the cycle after the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int kind = 0);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 2000) begin @(negedge clk); n++; end
        if (!in_ready) begin flag("issue_timeout"); return; end
        @(posedge clk); #1;
        if (kind != 1 && rd != 0) begin
            if (kind == 0) exp_q.push_back('{rd, golden(f3, a, b)});
            if (kind != 3 && !is_special(f3, a, b)) ln_q.push_back('{f3, a, b});
        end
        in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
        flush = (kind == 1);
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((!in_ready || exp_q.size() != 0) && n < 3000) begin @(negedge clk); n++; end
        if (!in_ready || exp_q.size() != 0) flag("idle_timeout");
    endtask

    task automatic wait_wb();
        int n = 0;
        @(negedge clk);
        while (!wb_valid && n < 200) begin @(negedge clk); n++; end
        if (!wb_valid) flag("wb_valid_timeout");
    endtask

    task automatic wait_start();
        int n = 0;
        @(negedge clk);
        while (!md_start && n < 200) begin @(negedge clk); n++; end
        if (!md_start) flag("md_start_timeout");
    endtask

    task automatic wait_mdready(output bit saw_wv);
        int n = 0;
        saw_wv = 1'b0;
        @(negedge clk);
        while (!md_ready && n < 200) begin
            saw_wv |= wb_valid;
            @(negedge clk); n++;
        end
        saw_wv |= wb_valid;
        if (!md_ready) flag("md_ready_timeout");
    endtask

    logic [2:0]  sp_f3 [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] sp_a  [4] = '{32'd100, 32'd100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] sp_b  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] sp_r  [4] = '{32'hFFFF_FFFF, 32'd100, 32'h8000_0000, 32'd0};

    initial begin : main
        int  s0;
        bit  saw;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;

        // Reset values
        cyc(2);
        @(negedge clk);
        chk("rst_md_start", md_start, 0);
        chk("rst_md_opcode", md_opcode, 0);
        chk("rst_md_rs1", md_rs1, 0);
        chk("rst_md_rs2", md_rs2, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);

        // MUL 10*10
        s0 = start_cnt;
        issue(3'd0, 32'd10, 32'd10, 5'd5);
        @(negedge clk);
        chk("mul_in_ready_busy", in_ready, 0);
        wait_idle();
        chk("mul_start_count", start_cnt - s0, 1);

        // DIV 100/7 and REMU 100/7 with writeback back-pressure
        rdy_mode = 2;
        issue(3'd4, 32'd100, 32'd7, 5'd3);
        wait_wb();
        repeat (5) begin
            @(negedge clk);
            chk("div_hold_data", wb_data, 32'h0000_000E);
            chk("div_hold_rd", wb_rd, 5'd3);
            chk("div_hold_in_ready", in_ready, 0);
        end
        rdy_mode = 0;
        wait_idle();
        rdy_mode = 2;
        issue(3'd7, 32'd100, 32'd7, 5'd7);
        wait_wb();
        repeat (5) begin
            @(negedge clk);
            chk("remu_hold_data", wb_data, 32'h0000_0002);
            chk("remu_hold_in_ready", in_ready, 0);
        end
        rdy_mode = 0;
        wait_idle();

        // Locally resolved divides: result the cycle after accept, no launch
        for (int i = 0; i < 4; i++) begin
            rdy_mode = 2;
            cyc();
            s0 = start_cnt;
            issue(sp_f3[i], sp_a[i], sp_b[i], 5'd9);
            @(negedge clk);
            chk("special_latency", wb_valid, 1);
            chk("special_data", wb_data, sp_r[i]);
            rdy_mode = 0;
            wait_idle();
            chk("special_no_start", start_cnt - s0, 0);
        end

        // Flush in WAIT drains the unit's result
        kfix = 6;
        issue(3'd4, 32'd100, 32'd7, 5'd3, 2);
        wait_start();
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0;
        wait_mdready(saw);
        chk("drain_no_wb_valid", saw, 0);
        chk("drain_in_ready_at_md_ready", in_ready, 0);
        @(negedge clk);
        chk("drain_in_ready_after", in_ready, 1);
        chk("drain_wb_valid_after", wb_valid, 0);

        // Flush in HOLD
        kfix = 2;
        rdy_mode = 2;
        issue(3'd0, 32'd7, 32'd6, 5'd4, 2);
        wait_wb();
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0;
        @(negedge clk);
        chk("hold_flush_wb_valid", wb_valid, 0);
        chk("hold_flush_in_ready", in_ready, 1);
        rdy_mode = 0;

        // rd == 0 and flush together with in_valid: nothing happens
        s0 = start_cnt;
        issue(3'd0, 32'd5, 32'd5, 5'd0);
        issue(3'd0, 32'd5, 32'd5, 5'd8, 1);
        repeat (4) begin
            @(negedge clk);
            chk("consume_wb_valid", wb_valid, 0);
            chk("consume_in_ready", in_ready, 1);
        end
        chk("consume_no_start", start_cnt - s0, 0);

        // LAUNCH held by md_busy, then launched
        cyc(); ext_busy = 1'b1;
        s0 = start_cnt;
        issue(3'd0, 32'd3, 32'd3, 5'd6);
        repeat (3) begin
            @(negedge clk);
            chk("launch_hold_start", md_start, 0);
            chk("launch_hold_in_ready", in_ready, 0);
        end
        cyc(); ext_busy = 1'b0;
        wait_idle();
        chk("launch_hold_start_count", start_cnt - s0, 1);

        // Flush in LAUNCH before the pulse
        ext_busy = 1'b1;
        s0 = start_cnt;
        issue(3'd1, 32'd3, 32'd3, 5'd6, 3);
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0; ext_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("launch_flush_in_ready", in_ready, 1);
        chk("launch_flush_no_start", start_cnt - s0, 0);

        // Asynchronous reset during WAIT
        kfix = 8;
        issue(3'd4, 32'd100, 32'd7, 5'd3, 2);
        wait_start();
        cyc(2);
        stab_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_md_start", md_start, 0);
        chk("arst_md_opcode", md_opcode, 0);
        chk("arst_md_rs1", md_rs1, 0);
        chk("arst_md_rs2", md_rs2, 0);
        chk("arst_wb_valid", wb_valid, 0);
        chk("arst_wb_rd", wb_rd, 0);
        chk("arst_wb_data", wb_data, 0);
        chk("arst_in_ready", in_ready, 1);
        cyc(); rst_n = 1'b1;
        wait_mdready(saw);
        @(negedge clk);
        saw |= wb_valid;
        chk("late_md_ready_no_wb", saw, 0);
        stab_en = 1'b1;
        kfix = 3;
        issue(3'd0, 32'd3, 32'd4, 5'd12);
        wait_idle();

        // Randomized traffic
        kfix = 0;
        rdy_mode = 1;
        busy_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       a = 32'h8000_0000;
                1, 2:    a = $urandom_range(0, 200);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2, 3:    b = $urandom_range(1, 50);
                default: b = $urandom;
            endcase
            rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            issue(f3, a, b, rd, ($urandom_range(0, 11) == 0) ? 1 : 0);
        end
        busy_rand = 1'b0;
        cyc(2);
        ext_busy = 1'b0;
        rdy_mode = 0;
        wait_idle();
        cyc(10);
        chk("final_exp_queue", exp_q.size(), 0);
        chk("final_launch_queue", ln_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
